// File: rtl/popcount_frame_acc.sv
// Per-frame ones/beat counter over 7-bit words using a 4-FA carry-save tree, saturating with overflow flag.
// Result appears 1 cycle after the last beat; a pending result that is not being taken stalls all input beats.
module popcount_frame_acc #(
  parameter int W_CNT   = 16,
  parameter int W_BEATS = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  logic [6:0]         in_dat,
  input  logic               in_last,
  output logic               in_rdy,
  output logic               out_vld,
  output logic [W_CNT-1:0]   out_cnt,
  output logic [W_BEATS-1:0] out_beats,
  output logic               out_ovf,
  input  logic               out_rdy
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t             state;
  logic [W_CNT-1:0]   acc;
  logic [W_BEATS-1:0] beats;
  logic               ovf;

  logic               acc_fire;
  logic               out_fire;
  logic [1:0]         fa0, fa1, fa2, fa3;
  logic [2:0]         pc;
  logic [W_CNT-1:0]   base_acc, nxt_acc;
  logic [W_BEATS-1:0] base_beats, nxt_beats;
  logic               base_ovf, nxt_ovf;
  logic [W_CNT:0]     sum;
  logic [W_BEATS:0]   bsum;

  // Returns {carry, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Conservative: stall every beat while an untaken result is held.
  assign in_rdy   = !rst && (!out_vld || out_rdy);
  assign acc_fire = in_vld && in_rdy;
  assign out_fire = out_vld && out_rdy;

  assign fa0 = fa(in_dat[2], in_dat[1], in_dat[0]);
  assign fa1 = fa(in_dat[5], in_dat[4], in_dat[3]);
  assign fa2 = fa(fa0[0], fa1[0], in_dat[6]);
  assign fa3 = fa(fa0[1], fa1[1], fa2[1]);
  assign pc  = {fa3[1], fa3[0], fa2[0]};

  // First beat of a frame starts from zero regardless of what the registers hold.
  assign base_acc   = (state == IDLE) ? '0 : acc;
  assign base_beats = (state == IDLE) ? '0 : beats;
  assign base_ovf   = (state == IDLE) ? 1'b0 : ovf;

  assign sum       = {1'b0, base_acc} + {{(W_CNT-2){1'b0}}, pc};
  assign bsum      = {1'b0, base_beats} + {{W_BEATS{1'b0}}, 1'b1};
  assign nxt_acc   = sum[W_CNT] ? '1 : sum[W_CNT-1:0];
  assign nxt_beats = bsum[W_BEATS] ? '1 : bsum[W_BEATS-1:0];
  assign nxt_ovf   = base_ovf | sum[W_CNT] | bsum[W_BEATS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      beats     <= '0;
      ovf       <= 1'b0;
      out_vld   <= 1'b0;
      out_cnt   <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_fire) begin
        out_vld <= 1'b0;
      end
      if (acc_fire) begin
        if (in_last) begin
          // A simultaneous take of the old result is overridden by the new one.
          out_vld   <= 1'b1;
          out_cnt   <= nxt_acc;
          out_beats <= nxt_beats;
          out_ovf   <= nxt_ovf;
          acc       <= '0;
          beats     <= '0;
          ovf       <= 1'b0;
          state     <= IDLE;
        end else begin
          acc   <= nxt_acc;
          beats <= nxt_beats;
          ovf   <= nxt_ovf;
          state <= ACC;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Drives one stimulus stream into a default-width and a 4-bit-count instance; a monitor scoreboards both.
`timescale 1ns/1ps
module tb_popcount_frame_acc;

  typedef struct {
    int cnt;
    int beats;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic [6:0]  in_dat = '0;
  logic        in_last = 1'b0;
  logic        out_rdy = 1'b0;

  logic        in_rdy, out_vld, out_ovf;
  logic [15:0] out_cnt;
  logic [11:0] out_beats;
  logic        in_rdy4, out_vld4, out_ovf4;
  logic [3:0]  out_cnt4;
  logic [11:0] out_beats4;

  int   errors = 0;
  int   checks = 0;
  bit   rdy_rand = 1'b0;
  exp_t q16[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  popcount_frame_acc u_dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_last(in_last),
    .in_rdy(in_rdy), .out_vld(out_vld), .out_cnt(out_cnt), .out_beats(out_beats),
    .out_ovf(out_ovf), .out_rdy(out_rdy)
  );

  popcount_frame_acc #(.W_CNT(4), .W_BEATS(12)) u_dut4 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_dat(in_dat), .in_last(in_last),
    .in_rdy(in_rdy4), .out_vld(out_vld4), .out_cnt(out_cnt4), .out_beats(out_beats4),
    .out_ovf(out_ovf4), .out_rdy(out_rdy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input int c16, input int b, input bit o16, input int c4, input bit o4);
    exp_t e;
    e.cnt = c16; e.beats = b; e.ovf = o16;
    q16.push_back(e);
    e.cnt = c4; e.ovf = o4;
    q4.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [6:0] d, input logic last);
    bit r;
    int guard;
    in_vld = 1'b1; in_dat = d; in_last = last;
    r = 1'b0;
    guard = 0;
    while (!r) begin
      @(negedge clk);
      r = in_rdy;
      tick();
      guard++;
      if (guard > 2000) begin
        errors++;
        $display("FAIL send_timeout: got in_rdy=0 for %0d cycles expected acceptance", guard);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "stalled");
      end
    end
    in_vld = 1'b0; in_last = 1'b0;
  endtask

  // Scoreboard monitor plus hold-stability check on both instances.
  initial begin
    exp_t e;
    bit pend = 1'b0, pend4 = 1'b0;
    logic [15:0] p_cnt;  logic [11:0] p_beats;  logic p_ovf;
    logic [3:0]  p_cnt4; logic [11:0] p_beats4; logic p_ovf4;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pend) begin
          chk("hold_cnt", out_cnt, p_cnt);
          chk("hold_beats", out_beats, p_beats);
          chk("hold_ovf", out_ovf, p_ovf);
        end
        if (pend4) begin
          chk("hold_cnt4", out_cnt4, p_cnt4);
          chk("hold_beats4", out_beats4, p_beats4);
          chk("hold_ovf4", out_ovf4, p_ovf4);
        end
        if (out_vld && out_rdy) begin
          if (q16.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = q16.pop_front();
            chk("cnt", out_cnt, e.cnt);
            chk("beats", out_beats, e.beats);
            chk("ovf", out_ovf, e.ovf);
          end
        end
        if (out_vld4 && out_rdy) begin
          if (q4.size() == 0) chk("unexpected_result4", 1, 0);
          else begin
            e = q4.pop_front();
            chk("cnt4", out_cnt4, e.cnt);
            chk("beats4", out_beats4, e.beats);
            chk("ovf4", out_ovf4, e.ovf);
          end
        end
      end
      pend  = !rst && out_vld && !out_rdy;
      pend4 = !rst && out_vld4 && !out_rdy;
      p_cnt = out_cnt;   p_beats = out_beats;   p_ovf = out_ovf;
      p_cnt4 = out_cnt4; p_beats4 = out_beats4; p_ovf4 = out_ovf4;
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got no end of run expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, sum, guard;
    logic [6:0] d;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_out_ovf", out_ovf, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", in_rdy, 1);
    tick();

    // 3-beat frame: 7 + 0 + 4
    out_rdy = 1'b1;
    push(11, 3, 0, 11, 0);
    send(7'h7F, 0); send(7'h00, 0); send(7'h55, 1);
    @(negedge clk);
    chk("latency_out_vld", out_vld, 1);
    tick();

    // Back-to-back single-beat frames
    push(2, 1, 0, 2, 0);
    push(1, 1, 0, 1, 0);
    send(7'h41, 1);
    fork
      begin
        @(negedge clk);
        chk("b2b_vld0", out_vld, 1);
        chk("b2b_cnt0", out_cnt, 2);
        @(negedge clk);
        chk("b2b_vld1", out_vld, 1);
        chk("b2b_cnt1", out_cnt, 1);
      end
      send(7'h01, 1);
    join
    tick(); tick();

    // Backpressure: pending result stalls the next frame
    out_rdy = 1'b0;
    push(7, 1, 0, 7, 0);
    send(7'h7F, 1);
    in_vld = 1'b1; in_dat = 7'h03; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_rdy", in_rdy, 0);
      chk("bp_out_vld", out_vld, 1);
      chk("bp_out_cnt", out_cnt, 7);
      tick();
    end
    out_rdy = 1'b1;
    push(6, 2, 0, 6, 0);
    send(7'h03, 0); send(7'h0F, 1);
    tick(); tick();

    // Saturation on the 4-bit instance, then flag must not leak
    push(21, 3, 0, 15, 1);
    send(7'h7F, 0); send(7'h7F, 0); send(7'h7F, 1);
    push(2, 1, 0, 2, 0);
    send(7'h03, 1);
    tick(); tick();

    // Reset mid-frame discards the partial frame
    send(7'h7F, 0); send(7'h7F, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_rdy", in_rdy, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_vld", out_vld, 0);
    tick();
    push(1, 1, 0, 1, 0);
    send(7'h01, 1);
    tick(); tick();

    // Random frames with random gaps and random out_rdy
    rdy_rand = 1'b1;
    for (int f = 0; f < 1500; f++) begin
      n = $urandom_range(1, 20);
      sum = 0;
      for (int b = 0; b < n; b++) begin
        d = 7'($urandom());
        sum += $countones(d);
        if ($urandom_range(0, 3) == 0) tick();
        if (b == n - 1) push(sum, n, 0, (sum > 15) ? 15 : sum, sum > 15);
        send(d, b == n - 1);
      end
    end

    rdy_rand = 1'b0;
    out_rdy = 1'b1;
    guard = 0;
    while ((q16.size() != 0 || q4.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    chk("drain_q16", q16.size(), 0);
    chk("drain_q4", q4.size(), 0);
    finish_run();
  end

endmodule
